// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/VGA RAM port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 19;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_BYTE1 = 2'd1,
        C_RWAIT = 2'd2
    } cpu_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        VGA    = 2'd1,
        CPU_LO = 2'd2,
        CPU_HI = 2'd3
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, VGA and RAM-port signals around the arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // cpu_req is held stable until the cycle in which cpu_stall is low; that
    // edge completes the access. vga_req has no backpressure: a grant returns
    // vga_valid/vga_pixel exactly one cycle later, a loss is simply dropped.
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_two_byte;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_valid;
    logic [7:0]        vga_pixel;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    cpu_state_t        state_dbg;

    modport slave (
        input  cpu_req, cpu_we, cpu_two_byte, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  vga_req, vga_addr,
        output vga_valid, vga_pixel,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output state_dbg
    );

    modport master (
        output cpu_req, cpu_we, cpu_two_byte, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output vga_req, vga_addr,
        input  vga_valid, vga_pixel,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  state_dbg
    );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive CPU arbitration losses, saturating at LIMIT (LIMIT >= 1).
module arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic at_limit
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && cnt != LIMIT_V) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_limit = (cnt == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port byte RAM arbiter: CPU memory stage vs. VGA scan-out, VGA
// preferred, with a bounded CPU starvation window.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    cpu_state_t        state, state_nxt;
    rd_tag_t           rd_tag, rd_tag_nxt;
    logic [7:0]        lo_q;
    logic              cpu_elig, vga_elig, cpu_win, vga_win, cpu_lose;
    logic              at_limit, hi_byte, final_byte, wr_ack, rd_ack;
    logic [ADDR_W-1:0] cpu_byte_addr;
    logic              unused_wdata_hi;

    // Grants are masked during reset so a held request cannot write mid-reset.
    assign hi_byte       = (state == C_BYTE1);
    assign final_byte    = hi_byte | ~bus.cpu_two_byte;
    assign cpu_elig      = ~reset & bus.cpu_req & (state == C_IDLE || state == C_BYTE1);
    assign vga_elig      = ~reset & bus.vga_req;
    assign cpu_win       = cpu_elig & (~vga_elig | at_limit);
    assign vga_win       = vga_elig & ~cpu_win;
    assign cpu_lose      = cpu_elig & ~cpu_win;
    assign cpu_byte_addr = bus.cpu_addr + ADDR_W'(hi_byte);
    assign wr_ack        = cpu_win & bus.cpu_we & final_byte;
    assign rd_ack        = ~reset & bus.cpu_req & (state == C_RWAIT);
    assign unused_wdata_hi = ^bus.cpu_wdata[DATA_W-1:16];

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (cpu_lose),
        .clear    (~cpu_lose),
        .at_limit (at_limit)
    );

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        if (cpu_win) begin
            bus.ram_addr  = cpu_byte_addr;
            bus.ram_we    = bus.cpu_we;
            bus.ram_wdata = hi_byte ? bus.cpu_wdata[15:8] : bus.cpu_wdata[7:0];
        end else if (vga_win) begin
            bus.ram_addr = bus.vga_addr;
        end
    end

    always_comb begin
        bus.cpu_stall  = ~reset & bus.cpu_req & ~(wr_ack | rd_ack);
        bus.cpu_rvalid = rd_ack;
        bus.cpu_rdata  = '0;
        if (rd_ack) begin
            bus.cpu_rdata = bus.cpu_two_byte ? DATA_W'({bus.ram_rdata, lo_q})
                                             : DATA_W'(bus.ram_rdata);
        end
        bus.vga_valid = (rd_tag == VGA);
        bus.vga_pixel = (rd_tag == VGA) ? bus.ram_rdata : 8'h00;
        bus.state_dbg = state;
    end

    always_comb begin
        state_nxt  = state;
        rd_tag_nxt = NONE;
        if (vga_win) begin
            rd_tag_nxt = VGA;
        end else if (cpu_win && !bus.cpu_we) begin
            rd_tag_nxt = hi_byte ? CPU_HI : CPU_LO;
        end
        case (state)
            C_IDLE: begin
                if (cpu_win) begin
                    if (bus.cpu_two_byte) state_nxt = C_BYTE1;
                    else                  state_nxt = bus.cpu_we ? C_IDLE : C_RWAIT;
                end
            end
            C_BYTE1: begin
                if (!bus.cpu_req)  state_nxt = C_IDLE;
                else if (cpu_win)  state_nxt = bus.cpu_we ? C_IDLE : C_RWAIT;
            end
            C_RWAIT: state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
    end

    // A dropped request discards an in-flight low byte rather than capturing it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= C_IDLE;
            rd_tag <= NONE;
            lo_q   <= '0;
        end else begin
            state  <= state_nxt;
            rd_tag <= rd_tag_nxt;
            if (rd_tag == CPU_LO && bus.cpu_req) begin
                lo_q <= bus.ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte RAM and read scoreboards.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int SL = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]    mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [7:0]    pl_data = '0;

    always @(posedge clk) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end

    int total = 0;
    int bad = 0;
    logic [DW-1:0] cpu_exp_q[$];
    logic [7:0]    vga_exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.cpu_rvalid === 1'b1) begin
            total++;
            assert (cpu_exp_q.size() > 0) else begin
                bad++;
                $error("FAIL cpu_rvalid_unexpected: got rvalid=1 want no read pending");
            end
            if (cpu_exp_q.size() > 0)
                check("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_exp_q.pop_front()));
        end
        if (bus.vga_valid === 1'b1) begin
            total++;
            assert (vga_exp_q.size() > 0) else begin
                bad++;
                $error("FAIL vga_valid_unexpected: got valid=1 want no pixel pending");
            end
            if (vga_exp_q.size() > 0)
                check("vga_pixel", 32'(bus.vga_pixel), 32'(vga_exp_q.pop_front()));
        end else begin
            check("vga_pixel_idle", 32'(bus.vga_pixel), 32'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        cyc();
        pl_en = 1'b0;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic two,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.cpu_req = req;
        bus.cpu_we = we;
        bus.cpu_two_byte = two;
        bus.cpu_addr = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic read2(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
        cyc();
        cpu_drive(1'b1, 1'b0, 1'b1, addr, '0);
        cpu_exp_q.push_back(exp);
        smp();
        check({tag, "_t0_state"}, 32'(bus.state_dbg), 32'(C_IDLE));
        check({tag, "_t0_addr"}, 32'(bus.ram_addr), 32'(addr));
        check({tag, "_t0_stall"}, 32'(bus.cpu_stall), 32'h1);
        cyc();
        smp();
        check({tag, "_t1_addr"}, 32'(bus.ram_addr), 32'(AW'(addr + AW'(1))));
        check({tag, "_t1_stall"}, 32'(bus.cpu_stall), 32'h1);
        cyc();
        smp();
        check({tag, "_t2_rvalid"}, 32'(bus.cpu_rvalid), 32'h1);
        check({tag, "_t2_stall"}, 32'(bus.cpu_stall), 32'h0);
        cyc();
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        logic win;
        cpu_drive(1'b1, 1'b1, 1'b0, AW'(32'h55), DW'(32'h99));
        bus.vga_req = 1'b0;
        bus.vga_addr = '0;

        cyc();
        preload(AW'(32'h00100), 8'h34);
        preload(AW'(32'h00101), 8'h12);
        preload(AW'(32'h12C00), 8'h5A);
        preload(AW'(32'h00201), 8'h77);
        smp();
        check("rst_ram_we", 32'(bus.ram_we), 32'h0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        check("rst_stall", 32'(bus.cpu_stall), 32'h0);
        check("rst_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        check("rst_vga_valid", 32'(bus.vga_valid), 32'h0);
        check("rst_state", 32'(bus.state_dbg), 32'(C_IDLE));
        cyc();
        bus.cpu_req = 1'b0;
        cyc();
        reset = 1'b0;

        // 1-byte write while idle
        cyc();
        cpu_drive(1'b1, 1'b1, 1'b0, AW'(32'h00010), DW'(32'h000AB));
        smp();
        check("w1_we", 32'(bus.ram_we), 32'h1);
        check("w1_addr", 32'(bus.ram_addr), 32'h00010);
        check("w1_wdata", 32'(bus.ram_wdata), 32'hAB);
        check("w1_stall", 32'(bus.cpu_stall), 32'h0);
        cyc();
        bus.cpu_req = 1'b0;
        smp();
        check("w1_state", 32'(bus.state_dbg), 32'(C_IDLE));

        // 2-byte read, little-endian
        read2(AW'(32'h00100), DW'(32'h01234), "r2");

        // single VGA read
        cyc();
        bus.vga_req = 1'b1;
        bus.vga_addr = AW'(32'h12C00);
        vga_exp_q.push_back(8'h5A);
        smp();
        check("vga_addr", 32'(bus.ram_addr), 32'h12C00);
        check("vga_we", 32'(bus.ram_we), 32'h0);
        cyc();
        bus.vga_req = 1'b0;
        smp();
        check("vga_valid", 32'(bus.vga_valid), 32'h1);

        // VGA held high against back-to-back CPU 1-byte writes
        cyc();
        bus.vga_req = 1'b1;
        for (int i = 0; i < 3 * (SL + 1); i++) begin
            if (i > 0) cyc();
            cpu_drive(1'b1, 1'b1, 1'b0, AW'(32'h300 + i / (SL + 1)), DW'(32'h20 + i / (SL + 1)));
            win = ((i % (SL + 1)) == SL);
            if (!win) vga_exp_q.push_back(8'h5A);
            smp();
            if (win) begin
                check("starve_cpu_addr", 32'(bus.ram_addr), 32'h300 + 32'(i / (SL + 1)));
                check("starve_cpu_we", 32'(bus.ram_we), 32'h1);
                check("starve_cpu_wdata", 32'(bus.ram_wdata), 32'h20 + 32'(i / (SL + 1)));
                check("starve_cpu_stall", 32'(bus.cpu_stall), 32'h0);
            end else begin
                check("starve_vga_addr", 32'(bus.ram_addr), 32'h12C00);
                check("starve_vga_we", 32'(bus.ram_we), 32'h0);
                check("starve_vga_stall", 32'(bus.cpu_stall), 32'h1);
            end
            if (i == SL + 1) check("starve_no_valid", 32'(bus.vga_valid), 32'h0);
        end
        cyc();
        bus.vga_req = 1'b0;
        bus.cpu_req = 1'b0;

        // 2-byte write wrapping the top of the address space
        cyc();
        cpu_drive(1'b1, 1'b1, 1'b1, AW'(32'h7FFFF), DW'(32'h0BEEF));
        smp();
        check("wrap_t0_addr", 32'(bus.ram_addr), 32'h7FFFF);
        check("wrap_t0_wdata", 32'(bus.ram_wdata), 32'hEF);
        check("wrap_t0_stall", 32'(bus.cpu_stall), 32'h1);
        cyc();
        smp();
        check("wrap_t1_addr", 32'(bus.ram_addr), 32'h00000);
        check("wrap_t1_wdata", 32'(bus.ram_wdata), 32'hBE);
        check("wrap_t1_we", 32'(bus.ram_we), 32'h1);
        check("wrap_t1_stall", 32'(bus.cpu_stall), 32'h0);
        cyc();
        bus.cpu_req = 1'b0;
        read2(AW'(32'h7FFFF), DW'(32'h0BEEF), "wrap_rd");

        // read request dropped in C_BYTE1 aborts without ack
        cyc();
        cpu_drive(1'b1, 1'b0, 1'b1, AW'(32'h00100), '0);
        smp();
        cyc();
        bus.cpu_req = 1'b0;
        smp();
        check("drop_stall", 32'(bus.cpu_stall), 32'h0);
        check("drop_we", 32'(bus.ram_we), 32'h0);
        cyc();
        smp();
        check("drop_state", 32'(bus.state_dbg), 32'(C_IDLE));
        check("drop_rvalid", 32'(bus.cpu_rvalid), 32'h0);

        // reset asserted in C_BYTE1 of a 2-byte write
        cyc();
        cpu_drive(1'b1, 1'b1, 1'b1, AW'(32'h00200), DW'(32'h05566));
        smp();
        check("rstmid_b0_we", 32'(bus.ram_we), 32'h1);
        check("rstmid_b0_addr", 32'(bus.ram_addr), 32'h00200);
        cyc();
        reset = 1'b1;
        smp();
        check("rstmid_we", 32'(bus.ram_we), 32'h0);
        check("rstmid_addr", 32'(bus.ram_addr), 32'h0);
        check("rstmid_wdata", 32'(bus.ram_wdata), 32'h0);
        check("rstmid_stall", 32'(bus.cpu_stall), 32'h0);
        check("rstmid_state", 32'(bus.state_dbg), 32'(C_IDLE));
        cyc();
        bus.cpu_req = 1'b0;
        cyc();
        reset = 1'b0;
        read2(AW'(32'h00200), DW'(32'h07766), "rstmid_rd");

        cyc();
        cyc();
        smp();
        check("cpu_q_empty", 32'(cpu_exp_q.size()), 32'h0);
        check("vga_q_empty", 32'(vga_exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
